fb_port_arbiter: RTL and testbench

- Shares the single-port framebuffer RAM between two requesters: the VGA scan-out prefetcher and the core's memory-mapped CPU port.
- VGA has priority because it has a hard deadline. A starvation counter guarantees the CPU a slot.
- The block sits between the core/scan-out logic and the framebuffer RAM, which has a 1-cycle registered read.
- Pixel words are 14 bits and feed vgaData downstream.

---
 rtl/fb_arb_pkg.sv | 33 +++
 rtl/fb_port_arbiter_if.sv | 40 ++++
 rtl/fb_arb_ret_pipe.sv | 58 +++++
 rtl/fb_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared widths, owner tag type and small helpers for the
// framebuffer port arbiter.
package fb_arb_pkg;

    localparam int unsigned DEF_ADDR_W   = 32'd15;
    localparam int unsigned DEF_DATA_W   = 32'd14;
    localparam int unsigned STARVE_CNT_W = 32'd4;
    localparam int unsigned STATS_W      = 32'd16;
    localparam int unsigned WAIT_W       = 32'd4;

    // Who owns the read data returning from the RAM two cycles after a grant.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_VGA    = 2'd1,
        OWN_CPU_RD = 2'd2
    } owner_t;

    // Tag launched with an access: CPU writes return nothing, so they carry OWN_NONE.
    function automatic owner_t grant_tag(input logic vga_gnt,
                                         input logic cpu_gnt,
                                         input logic cpu_we);
        owner_t tag;
        if (vga_gnt) begin
            tag = OWN_VGA;
        end else if (cpu_gnt && !cpu_we) begin
            tag = OWN_CPU_RD;
        end else begin
            tag = OWN_NONE;
        end
        return tag;
    endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: requester, return-data and RAM-side signals of the
// framebuffer port arbiter. slave = arbiter side, master = surroundings.
interface fb_port_arbiter_if #(
    parameter int unsigned ADDR_W = fb_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = fb_arb_pkg::DEF_DATA_W
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              starve_force;

    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, starve_force
    );

    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, starve_force
    );
endinterface

// File: rtl/fb_arb_ret_pipe.sv
// fb_arb_ret_pipe: two-stage owner tag pipeline matching the grant -> mem_* ->
// RAM read latency; steers mem_rdata to the owning requester.
module fb_arb_ret_pipe
    import fb_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  owner_t            issue_tag,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata
);

    owner_t tag_s1_r;
    owner_t tag_s2_r;

    // Shift the owner tag along with the access; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_s1_r <= OWN_NONE;
            tag_s2_r <= OWN_NONE;
        end else begin
            tag_s1_r <= issue_tag;
            tag_s2_r <= tag_s1_r;
        end
    end

    // Raise only the owner's rvalid; non-owner data is held at zero, and nothing
    // is returned while reset is asserted.
    always_comb begin
        vga_rvalid = 1'b0;
        cpu_rvalid = 1'b0;
        vga_rdata  = {DATA_W{1'b0}};
        cpu_rdata  = {DATA_W{1'b0}};
        if (reset) begin
            vga_rvalid = 1'b0;
        end else begin
            case (tag_s2_r)
                OWN_VGA: begin
                    vga_rvalid = 1'b1;
                    vga_rdata  = mem_rdata;
                end
                OWN_CPU_RD: begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = mem_rdata;
                end
                default: begin
                    vga_rvalid = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port framebuffer RAM between the VGA
// prefetcher (priority) and the CPU port, with a starvation counter that forces
// a CPU slot after STARVE_LIMIT (1..15) consecutive VGA wins under contention.
// Define FB_ARB_STATS_EN to add the CPU wait / preemption statistics outputs.
module fb_port_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = 32'd4
) (
    input  logic               clk,
    input  logic               reset,
    fb_port_arbiter_if.slave   bus
`ifdef FB_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] cpu_wait_cycles,
    output logic [STATS_W-1:0] vga_preempt_cnt,
    output logic [WAIT_W-1:0]  max_cpu_wait
`endif
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C    = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] CNT_ZERO_C = {STARVE_CNT_W{1'b0}};
    localparam logic [STARVE_CNT_W-1:0] CNT_ONE_C  = {{(STARVE_CNT_W-1){1'b0}}, 1'b1};

    logic [STARVE_CNT_W-1:0] starve_cnt_r;
    logic [STARVE_CNT_W-1:0] starve_cnt_nxt_s;
    logic                    vga_gnt_s;
    logic                    cpu_gnt_s;
    logic                    force_s;
    owner_t                  issue_tag_s;

    logic                    mem_en_r;
    logic                    mem_we_r;
    logic [ADDR_W-1:0]       mem_addr_r;
    logic [DATA_W-1:0]       mem_wdata_r;

    logic                    vga_rvalid_s;
    logic                    cpu_rvalid_s;
    logic [DATA_W-1:0]       vga_rdata_s;
    logic [DATA_W-1:0]       cpu_rdata_s;

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= CNT_ZERO_C;
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    // Grant decision: VGA wins contention until the counter reaches the limit,
    // then the CPU is forced in. The counter only grows while the CPU is waiting
    // behind VGA, so it saturates at the limit and never wraps.
    always_comb begin
        vga_gnt_s        = 1'b0;
        cpu_gnt_s        = 1'b0;
        force_s          = 1'b0;
        starve_cnt_nxt_s = CNT_ZERO_C;
        if (reset) begin
            starve_cnt_nxt_s = CNT_ZERO_C;
        end else if (bus.vga_req && bus.cpu_req) begin
            if (starve_cnt_r >= LIMIT_C) begin
                cpu_gnt_s        = 1'b1;
                force_s          = 1'b1;
                starve_cnt_nxt_s = CNT_ZERO_C;
            end else begin
                vga_gnt_s        = 1'b1;
                starve_cnt_nxt_s = starve_cnt_r + CNT_ONE_C;
            end
        end else if (bus.vga_req) begin
            vga_gnt_s        = 1'b1;
            starve_cnt_nxt_s = CNT_ZERO_C;
        end else if (bus.cpu_req) begin
            cpu_gnt_s        = 1'b1;
            starve_cnt_nxt_s = CNT_ZERO_C;
        end else begin
            starve_cnt_nxt_s = CNT_ZERO_C;
        end
    end

    // Tag that travels with this cycle's access to the return pipeline.
    always_comb begin
        issue_tag_s = grant_tag(vga_gnt_s, cpu_gnt_s, bus.cpu_we);
    end

    // Register the granted access onto the RAM port; idle cycles drop mem_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            mem_en_r <= vga_gnt_s | cpu_gnt_s;
            mem_we_r <= cpu_gnt_s & bus.cpu_we;
            if (vga_gnt_s) begin
                mem_addr_r  <= bus.vga_addr;
                mem_wdata_r <= {DATA_W{1'b0}};
            end else if (cpu_gnt_s) begin
                mem_addr_r  <= bus.cpu_addr;
                mem_wdata_r <= bus.cpu_wdata;
            end else begin
                mem_addr_r  <= {ADDR_W{1'b0}};
                mem_wdata_r <= {DATA_W{1'b0}};
            end
        end
    end

    fb_arb_ret_pipe #(
        .DATA_W (DATA_W)
    ) u_ret_pipe (
        .clk        (clk),
        .reset      (reset),
        .issue_tag  (issue_tag_s),
        .mem_rdata  (bus.mem_rdata),
        .vga_rvalid (vga_rvalid_s),
        .vga_rdata  (vga_rdata_s),
        .cpu_rvalid (cpu_rvalid_s),
        .cpu_rdata  (cpu_rdata_s)
    );

    assign bus.vga_gnt      = vga_gnt_s;
    assign bus.cpu_gnt      = cpu_gnt_s;
    assign bus.starve_force = force_s;
    assign bus.mem_en       = mem_en_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.vga_rvalid   = vga_rvalid_s;
    assign bus.vga_rdata    = vga_rdata_s;
    assign bus.cpu_rvalid   = cpu_rvalid_s;
    assign bus.cpu_rdata    = cpu_rdata_s;

`ifdef FB_ARB_STATS_EN
    function automatic logic [STATS_W-1:0] sat_inc_stat(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + {{(STATS_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == {WAIT_W{1'b1}}) ? v : v + {{(WAIT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [STATS_W-1:0] wait_tot_r;
    logic [STATS_W-1:0] preempt_r;
    logic [WAIT_W-1:0]  wait_run_r;
    logic [WAIT_W-1:0]  wait_max_r;
    logic [WAIT_W-1:0]  wait_run_nxt_s;
    logic               cpu_waiting_s;

    // Length of the CPU's current unbroken wait, including this cycle.
    always_comb begin
        cpu_waiting_s  = bus.cpu_req & ~cpu_gnt_s;
        wait_run_nxt_s = {WAIT_W{1'b0}};
        if (cpu_waiting_s) begin
            wait_run_nxt_s = sat_inc_wait(wait_run_r);
        end else begin
            wait_run_nxt_s = {WAIT_W{1'b0}};
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_tot_r <= {STATS_W{1'b0}};
            preempt_r  <= {STATS_W{1'b0}};
            wait_run_r <= {WAIT_W{1'b0}};
            wait_max_r <= {WAIT_W{1'b0}};
        end else begin
            wait_run_r <= wait_run_nxt_s;
            if (cpu_waiting_s) begin
                wait_tot_r <= sat_inc_stat(wait_tot_r);
            end
            if (force_s) begin
                preempt_r <= sat_inc_stat(preempt_r);
            end
            if (wait_run_nxt_s > wait_max_r) begin
                wait_max_r <= wait_run_nxt_s;
            end
        end
    end

    assign cpu_wait_cycles = wait_tot_r;
    assign vga_preempt_cnt = preempt_r;
    assign max_cpu_wait    = wait_max_r;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_fb_port_arbiter;

    localparam int unsigned AW  = 32'd15;
    localparam int unsigned DW  = 32'd14;
    localparam int unsigned LIM = 32'd4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef FB_ARB_STATS_EN
    logic [15:0] cpu_wait_cycles;
    logic [15:0] vga_preempt_cnt;
    logic [3:0]  max_cpu_wait;
`endif

    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FB_ARB_STATS_EN
        ,
        .cpu_wait_cycles (cpu_wait_cycles),
        .vga_preempt_cnt (vga_preempt_cnt),
        .max_cpu_wait    (max_cpu_wait)
`endif
    );

    // Behavioural RAM with a one-cycle registered read.
    logic [DW-1:0] ram    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;
    assign bus.mem_rdata = ram_q;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
            else            ram_q = ram[bus.mem_addr];
        end
    end

    // Reference model: expected RAM accesses and read returns, each with its due cycle.
    typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_ev_t;
    typedef struct { int due; logic is_cpu; logic [DW-1:0] data; } rd_ev_t;
    mem_ev_t mem_q[$];
    rd_ev_t  rd_q[$];
    int      streak;      // consecutive VGA wins while the CPU waited
    int      cyc;
    int      st_tot, st_pre, st_run, st_max;

    int n_checks, n_errors;
    int n_vg, n_cg, n_force, n_vrv, n_crv, n_bad_addr;
    logic [DW-1:0] last_vrd, last_crd;
    logic last_vg, last_cg;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clr_obs();
        n_vg = 0; n_cg = 0; n_force = 0; n_vrv = 0; n_crv = 0; n_bad_addr = 0;
        last_vrd = '0; last_crd = '0;
    endtask

    // One clock cycle: check the DUT against the model, then advance the model.
    task automatic tick();
        logic cpu_turn, exp_vg, exp_cg, exp_force, exp_men;
        logic exp_vrv, exp_crv;
        logic [DW-1:0] exp_vrd, exp_crd;
        mem_ev_t me;
        rd_ev_t  re;
        @(negedge clk);
        cpu_turn  = bus.cpu_req && (!bus.vga_req || streak >= int'(LIM));
        exp_cg    = !reset && cpu_turn;
        exp_vg    = !reset && bus.vga_req && !cpu_turn;
        exp_force = exp_cg && bus.vga_req;
        check_val("vga_gnt", bus.vga_gnt, exp_vg);
        check_val("cpu_gnt", bus.cpu_gnt, exp_cg);
        check_val("starve_force", bus.starve_force, exp_force);

        exp_men = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            me = mem_q.pop_front();
            exp_men = 1'b1;
            check_val("mem_we", bus.mem_we, me.we);
            check_val("mem_addr", bus.mem_addr, me.addr);
            if (me.we) check_val("mem_wdata", bus.mem_wdata, me.wdata);
        end
        check_val("mem_en", bus.mem_en, exp_men);

        exp_vrv = 1'b0; exp_crv = 1'b0; exp_vrd = '0; exp_crd = '0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            re = rd_q.pop_front();
            if (!reset) begin
                if (re.is_cpu) begin exp_crv = 1'b1; exp_crd = re.data; end
                else           begin exp_vrv = 1'b1; exp_vrd = re.data; end
            end
        end
        check_val("vga_rvalid", bus.vga_rvalid, exp_vrv);
        check_val("vga_rdata", bus.vga_rdata, exp_vrd);
        check_val("cpu_rvalid", bus.cpu_rvalid, exp_crv);
        check_val("cpu_rdata", bus.cpu_rdata, exp_crd);

`ifdef FB_ARB_STATS_EN
        check_val("cpu_wait_cycles", cpu_wait_cycles, st_tot);
        check_val("vga_preempt_cnt", vga_preempt_cnt, st_pre);
        check_val("max_cpu_wait", max_cpu_wait, st_max);
`endif

        // Observations for the directed scenarios.
        n_vg    += int'(bus.vga_gnt);
        n_cg    += int'(bus.cpu_gnt);
        n_force += int'(bus.starve_force);
        if (bus.vga_rvalid) begin n_vrv++; last_vrd = bus.vga_rdata; end
        if (bus.cpu_rvalid) begin n_crv++; last_crd = bus.cpu_rdata; end
        if (bus.mem_en && bus.mem_addr == 15'h7ABC) n_bad_addr++;

        // Advance the model.
        if (exp_vg) begin
            me.due = cyc + 1; me.we = 1'b0; me.addr = bus.vga_addr; me.wdata = '0;
            mem_q.push_back(me);
            re.due = cyc + 2; re.is_cpu = 1'b0; re.data = shadow[bus.vga_addr];
            rd_q.push_back(re);
        end
        if (exp_cg) begin
            me.due = cyc + 1; me.we = bus.cpu_we; me.addr = bus.cpu_addr; me.wdata = bus.cpu_wdata;
            mem_q.push_back(me);
            if (bus.cpu_we) begin
                shadow[bus.cpu_addr] = bus.cpu_wdata;
            end else begin
                re.due = cyc + 2; re.is_cpu = 1'b1; re.data = shadow[bus.cpu_addr];
                rd_q.push_back(re);
            end
        end
        if (reset) begin
            mem_q.delete(); rd_q.delete();
            streak = 0; st_tot = 0; st_pre = 0; st_run = 0; st_max = 0;
        end else begin
            streak = (exp_vg && bus.cpu_req) ? streak + 1 : 0;
            if (bus.cpu_req && !exp_cg) begin
                st_tot = (st_tot < 65535) ? st_tot + 1 : st_tot;
                st_run = (st_run < 15) ? st_run + 1 : st_run;
            end else begin
                st_run = 0;
            end
            if (exp_force) st_pre = (st_pre < 65535) ? st_pre + 1 : st_pre;
            if (st_run > st_max) st_max = st_run;
        end
        last_vg = exp_vg;
        last_cg = exp_cg;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int waited;
        int pct;
        n_checks = 0; n_errors = 0; cyc = 0; streak = 0;
        st_tot = 0; st_pre = 0; st_run = 0; st_max = 0;
        last_vg = 1'b0; last_cg = 1'b0;
        clr_obs();
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = 14'h1000 + DW'(i);
            shadow[i] = 14'h1000 + DW'(i);
        end
        reset = 1'b1;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        @(posedge clk); #1;
        repeat (3) tick();
        reset = 1'b0;
        check_val("rst_mem_en", bus.mem_en, 1'b0);
        check_val("rst_vga_rvalid", bus.vga_rvalid, 1'b0);
        check_val("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);

        // VGA-only back-to-back reads of 0..3.
        clr_obs();
        for (int a = 0; a < 4; a++) begin
            bus.vga_req = 1'b1; bus.vga_addr = AW'(a);
            tick();
        end
        bus.vga_req = 1'b0;
        repeat (3) tick();
        check_val("t1_vga_gnts", n_vg, 4);
        check_val("t1_vga_rvalids", n_vrv, 4);
        check_val("t1_last_rdata", last_vrd, 14'h1003);

        // CPU write then read back.
        clr_obs();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0100; bus.cpu_wdata = 14'h2A5F;
        tick();
        bus.cpu_we = 1'b0;
        tick();
        bus.cpu_req = 1'b0;
        repeat (3) tick();
        check_val("t2_cpu_gnts", n_cg, 2);
        check_val("t2_cpu_rvalids", n_crv, 1);
        check_val("t2_cpu_rdata", last_crd, 14'h2A5F);

        // Sustained contention for 50 cycles starting from reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr_obs();
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0010;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0020;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_vg) bus.vga_addr = bus.vga_addr + 15'd1;
            if (last_cg) bus.cpu_addr = bus.cpu_addr + 15'd1;
        end
        check_val("t3_cpu_gnts", n_cg, 10);
        check_val("t3_vga_gnts", n_vg, 40);
        check_val("t3_forces", n_force, 10);
`ifdef FB_ARB_STATS_EN
        check_val("t3_preempt", vga_preempt_cnt, 16'd10);
        check_val("t3_max_wait", max_cpu_wait, 4'd4);
        check_val("t3_wait_tot", cpu_wait_cycles, 16'd40);
`endif
        bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (3) tick();

        // CPU request abandoned under VGA load, then a fresh one.
        clr_obs();
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0030;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 15'h7ABC; bus.cpu_wdata = 14'h1111;
        repeat (2) tick();
        bus.cpu_req = 1'b0;
        repeat (2) tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0042;
        waited = 0;
        while (waited < 20) begin
            tick();
            waited++;
            if (last_cg) break;
        end
        check_val("t4_cpu_slot_after", waited, 5);
        bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (3) tick();
        check_val("t4_bad_addr", n_bad_addr, 0);
        check_val("t4_cpu_gnts", n_cg, 1);

        // Reset while a VGA read and a CPU read are in flight.
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0005;
        tick();
        bus.vga_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0006;
        tick();
        bus.cpu_req = 1'b0;
        clr_obs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t5_mem_en_after_rst", bus.mem_en, 1'b0);
        repeat (3) tick();
        check_val("t5_vga_rvalids", n_vrv, 0);
        check_val("t5_cpu_rvalids", n_crv, 0);
        bus.vga_req = 1'b1; bus.vga_addr = 15'h0007;
        tick();
        check_val("t5_resume_gnt", last_vg, 1'b1);
        bus.vga_req = 1'b0;
        repeat (3) tick();
        check_val("t5_resume_rdata", last_vrd, 14'h1007);

        // Randomized traffic with abandoned requests and occasional resets.
        for (int blk = 0; blk < 4; blk++) begin
            pct = (blk == 0) ? 30 : (blk == 1) ? 70 : (blk == 2) ? 95 : 100;
            for (int i = 0; i < 1000; i++) begin
                if (last_vg || !bus.vga_req) begin
                    bus.vga_req  = ($urandom_range(0, 99) < pct);
                    bus.vga_addr = AW'($urandom_range(0, 63));
                end else if ($urandom_range(0, 99) < 3) begin
                    bus.vga_req = 1'b0;
                end
                if (last_cg || !bus.cpu_req) begin
                    bus.cpu_req   = ($urandom_range(0, 99) < 50);
                    bus.cpu_we    = $urandom_range(0, 1) == 1;
                    bus.cpu_addr  = AW'($urandom_range(0, 63));
                    bus.cpu_wdata = DW'($urandom());
                end else if ($urandom_range(0, 99) < 3) begin
                    bus.cpu_req = 1'b0;
                end
                reset = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        reset = 1'b0; bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
